score_tracker: RTL

- Parametrised BCD score/high-score unit for the runner game.
- Owns the game-phase FSM (IDLE/RUN/PAUSED/OVER) and counts prescaled frame ticks plus bonus pickups into a saturating BCD score.
- Latches a persistent high score at game over and emits a one-cycle milestone pulse every 100 points.
- Sits between the game controller (tick, bonus, start, pause, game_over) and the seven-segment/VGA score display.

---
 rtl/score_tracker.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
//   BCD score / high-score unit for the runner game. Owns the game-phase FSM
//   (IDLE/RUN/PAUSED/OVER), turns prescaled frame ticks and bonus pickups into
//   a saturating BCD score, keeps the best score since reset and pulses a
//   milestone strobe every time the score passes a multiple of 100.
//
// Parameters
//   DIGITS   : BCD digits in score/high_score (3..8)
//   TICK_DIV : qualifying ticks per +1 score (1..255)
//
// Ports
//   clk         in  system clock
//   reset       in  asynchronous, active-low reset
//   start       in  pulse, begins a new game (from IDLE or OVER)
//   pause       in  level, freezes scoring while high
//   game_over   in  pulse, ends the game (from RUN or PAUSED)
//   tick        in  frame strobe, prescaled into +1 score
//   bonus_valid in  strobe, adds min(bonus_amt,9) to the score
//   bonus_amt   in  bonus value, binary
//   score       out current score, BCD, digit 0 in the low nibble
//   high_score  out best score since reset, BCD
//   milestone   out one-cycle pulse on a carry out of the tens digit
//   new_high    out last finished game beat the previous high score
//   saturated   out score pinned at all 9s
//   state       out 0=IDLE 1=RUN 2=PAUSED 3=OVER
// -----------------------------------------------------------------------------
module score_tracker #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  game_over,
  input  logic                  tick,
  input  logic                  bonus_valid,
  input  logic [3:0]            bonus_amt,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  milestone,
  output logic                  new_high,
  output logic                  saturated,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int               W       = 4 * DIGITS;
  localparam logic [7:0]       PRE_MAX = 8'(TICK_DIV - 1);
  localparam logic [W-1:0]     ALL_9S  = {DIGITS{4'h9}};

  // BCD addition of a 0..10 increment into a DIGITS-wide score.
  // Returns {carry out of top digit, carry out of tens digit, sum}.
  function automatic logic [W+1:0] bcd_add(input logic [W-1:0] val,
                                           input logic [3:0]   add);
    logic [4:0]   dsum;
    logic         carry;
    logic         tens_c;
    logic [W-1:0] res;
    carry  = 1'b0;
    tens_c = 1'b0;
    res    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == 0) begin
        dsum = {1'b0, val[3:0]} + {1'b0, add};
      end else begin
        dsum = {1'b0, val[4*i +: 4]} + {4'd0, carry};
      end
      if (dsum > 5'd9) begin
        res[4*i +: 4] = 4'(dsum - 5'd10);
        carry         = 1'b1;
      end else begin
        res[4*i +: 4] = dsum[3:0];
        carry         = 1'b0;
      end
      if (i == 1) begin
        tens_c = carry;
      end else begin
        tens_c = tens_c;
      end
    end
    return {carry, tens_c, res};
  endfunction

  state_t        state_q, state_d;
  logic [W-1:0]  score_q, score_d;
  logic [W-1:0]  high_q, high_d;
  logic [7:0]    pre_q, pre_d;
  logic          sat_q, sat_d;
  logic          mile_q, mile_d;
  logic          nh_q, nh_d;

  logic          inc_s;
  logic [3:0]    bonus_clamped_s;
  logic [3:0]    add_s;
  logic [W+1:0]  sum_s;

  // Increment terms for the current cycle; only used when scoring is enabled.
  always_comb begin
    inc_s           = tick && (pre_q == PRE_MAX);
    bonus_clamped_s = (bonus_amt > 4'd9) ? 4'd9 : bonus_amt;
    add_s           = {3'd0, inc_s} + (bonus_valid ? bonus_clamped_s : 4'd0);
    sum_s           = bcd_add(score_q, add_s);
  end

  // Next-state, scoring, saturation and high-score logic.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    pre_d   = pre_q;
    sat_d   = sat_q;
    mile_d  = 1'b0;
    nh_d    = nh_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          score_d = '0;
          pre_d   = 8'd0;
          sat_d   = 1'b0;
          nh_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN, ST_PAUSED: begin
        if (game_over) begin
          // Strobes in the game_over cycle are dropped; digits are ordered
          // most-significant high, so a plain unsigned compare is BCD order.
          state_d = ST_OVER;
          if (score_q > high_q) begin
            high_d = score_q;
            nh_d   = 1'b1;
          end else begin
            high_d = high_q;
          end
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (state_q == ST_PAUSED) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
          if (tick) begin
            pre_d = inc_s ? 8'd0 : (pre_q + 8'd1);
          end else begin
            pre_d = pre_q;
          end
          // Once pinned, score stays at all 9s and no milestone is raised.
          if (!sat_q && (add_s != 4'd0)) begin
            if (sum_s[W+1]) begin
              score_d = ALL_9S;
              sat_d   = 1'b1;
            end else begin
              score_d = sum_s[W-1:0];
            end
            mile_d = sum_s[W];
          end else begin
            score_d = score_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      high_q  <= '0;
      pre_q   <= 8'd0;
      sat_q   <= 1'b0;
      mile_q  <= 1'b0;
      nh_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      pre_q   <= pre_d;
      sat_q   <= sat_d;
      mile_q  <= mile_d;
      nh_q    <= nh_d;
    end
  end

  assign score      = score_q;
  assign high_score = high_q;
  assign milestone  = mile_q;
  assign new_high   = nh_q;
  assign saturated  = sat_q;
  assign state      = state_q;

endmodule
